stream_sum_accumulator: RTL
===========================

Name: stream_sum_accumulator

Overview:
Sequential accumulator that drives the operand inputs of N_fulladder_module and registers its Sum and flag outputs. It adds a block of COUNT input samples (pixel values) into a running total. Inputs and outputs use valid/ready handshakes. It feeds filter stages that need windowed sums, such as averaging and brightness, and reports sticky carry/overflow and a final zero flag.

Parameters:
WIDTH, 4, data width of samples, accumulator and adder instance
COUNT, 4, samples accumulated per block (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin new block (clears accumulator and sticky flags)
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  WIDTH  sample to add
out_valid  output  1  block result available
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH
out_carry  output  1  sticky: any adder carry_flag during block
out_overflow  output  1  sticky: any adder overflow_flag (two's complement) during block
out_zero  output  1  out_sum == 0

Behaviour:
- Datapath: one internal N_fulladder_module #(WIDTH), with A=acc and B=in_data. Its Sum, carry_flag and overflow_flag are sampled only on an accepted beat.
- Reset (rst_n low, async): state=IDLE, acc=0, count=0, sticky flags=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_sum=0, out_carry=0, out_overflow=0, out_zero=0.
  - Reset mid-block discards all partial state. No output is produced for that block.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACCUM next cycle; acc, count and sticky flags clear to 0.
- ACCUM:
  - in_ready=1.
  - Accepted beat = in_valid & in_ready. On each accepted beat: acc<=Sum; carry_s|=carry_flag; ovf_s|=overflow_flag; count<=count+1.
  - Accepted beat with count==COUNT-1 -> DONE next cycle.
  - in_valid gaps stall the block without changing state. Throughput is 1 sample/cycle.
  - start is ignored.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_carry=carry_s, out_overflow=ovf_s, out_zero=(acc==0). All outputs are held stable while out_ready=0.
  - out_ready=1 with start=0 -> IDLE next cycle.
  - out_ready=1 with start=1 -> ACCUM next cycle, with a fresh clear (back-to-back blocks).
  - start with out_ready=0 is ignored.
- Latency: out_valid rises on the cycle after the COUNT-th accepted beat.
- Minimum block period is COUNT+1 cycles when out_ready is held high and start is held high.
- Width rule: sum wraps modulo 2^WIDTH. No saturation.
- out_* are registered and show no combinational path from in_data.
- out_sum/out_carry/out_overflow/out_zero hold the last delivered values outside DONE. Consumers qualify them with out_valid only.
- count width is clog2(COUNT+1).
- COUNT=1: DONE follows the first accepted beat.

Test Plan (WIDTH=4, COUNT=4, out_ready=1 unless stated):
- start, then samples 1,2,3,4 -> out_sum=1010, out_carry=0, out_overflow=1 (6+4 signed overflow), out_zero=0. out_valid occurs 1 cycle after the 4th beat.
- start, then samples 15,15,15,15 -> out_sum=1100, out_carry=1, out_overflow=0, out_zero=0.
- start, then samples 8,8,0,0 -> out_sum=0000, out_carry=1, out_overflow=1, out_zero=1. Checks that sticky flags survive later no-carry beats.
- start, then samples 0,0,0,0 with in_valid low on alternate cycles -> out_sum=0000, all flags 0, out_zero=1. in_ready stays 1 through the gaps and exactly 4 beats are counted.
- Backpressure: out_ready=0 for 3 cycles in DONE, with start pulsed -> outputs stable, in_ready=0, start ignored. Then out_ready=1 with start=1 -> ACCUM next cycle, and the new block (1,1,1,1) gives out_sum=0100 with flags cleared.
- Assert rst_n low after 2 beats of a block -> all outputs 0 immediately (async). After release, state is IDLE and in_ready=0 until start.

Source files
------------

// File: rtl/stream_sum_accumulator.sv
// Block accumulator: sums COUNT valid/ready samples through a ripple-carry adder
// and presents the wrapped total with sticky carry/overflow and a zero flag.

module N_fulladder_module #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             carry_flag,
  output logic             overflow_flag
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign carry_flag    = c[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow_flag = c[WIDTH] ^ c[WIDTH-1];
endmodule

module stream_sum_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_s_q, carry_s_d;
  logic             ovf_s_q, ovf_s_d;
  logic [WIDTH-1:0] sum_o_q, sum_o_d;
  logic             carry_o_q, carry_o_d;
  logic             ovf_o_q, ovf_o_d;
  logic             zero_o_q, zero_o_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_ovf;

  N_fulladder_module #(.WIDTH(WIDTH)) u_adder (
    .A             (acc_q),
    .B             (in_data),
    .Sum           (add_sum),
    .carry_flag    (add_carry),
    .overflow_flag (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carry_s_d = carry_s_q;
    ovf_s_d   = ovf_s_q;
    sum_o_d   = sum_o_q;
    carry_o_d = carry_o_q;
    ovf_o_d   = ovf_o_q;
    zero_o_d  = zero_o_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          carry_s_d = 1'b0;
          ovf_s_d   = 1'b0;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d     = add_sum;
          carry_s_d = carry_s_q | add_carry;
          ovf_s_d   = ovf_s_q | add_ovf;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // Result registers load on the final beat so out_* never track the
            // running total mid-block.
            state_d   = DONE;
            sum_o_d   = add_sum;
            carry_o_d = carry_s_q | add_carry;
            ovf_o_d   = ovf_s_q | add_ovf;
            zero_o_d  = (add_sum == '0);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (start) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            carry_s_d = 1'b0;
            ovf_s_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      carry_s_q <= 1'b0;
      ovf_s_q   <= 1'b0;
      sum_o_q   <= '0;
      carry_o_q <= 1'b0;
      ovf_o_q   <= 1'b0;
      zero_o_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      carry_s_q <= carry_s_d;
      ovf_s_q   <= ovf_s_d;
      sum_o_q   <= sum_o_d;
      carry_o_q <= carry_o_d;
      ovf_o_q   <= ovf_o_d;
      zero_o_q  <= zero_o_d;
    end
  end

  assign out_sum      = sum_o_q;
  assign out_carry    = carry_o_q;
  assign out_overflow = ovf_o_q;
  assign out_zero     = zero_o_q;
endmodule
